rv32_mem: RTL and testbench
===========================

Name: rv32_mem

Overview:
- Memory-access stage directly downstream of rv32_alu.
- Consumes the ALU result as the load/store effective address, or passes it through for non-memory ops.
- Runs a single-outstanding request/ready data-bus transaction, stalling upstream while it waits.
- Produces the registered writeback bundle for the register file.

Parameters:
- none (all widths fixed by RV32I)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- valid_in  in  1  upstream instruction valid
- flush_in  in  1  kill current/incoming instruction (branch mispredict)
- read_in  in  1  instruction is a load
- write_in  in  1  instruction is a store
- width_in  in  2  00 byte, 01 half, 10 word, 11 treated as word
- zero_extend_in  in  1  loads: 1 = LBU/LHU, 0 = sign-extend
- rd_in  in  5  destination register
- rd_write_in  in  1  instruction writes rd
- result_in  in  32  ALU result (address for ld/st, value otherwise)
- rs2_value_in  in  32  store data
- stall_out  out  1  upstream must hold its outputs
- bus_address_out  out  32  word-aligned address, bits[1:0] always 0
- bus_read_out  out  1  read strobe
- bus_write_out  out  1  write strobe
- bus_write_mask_out  out  4  byte-lane enables
- bus_write_value_out  out  32  lane-replicated store data
- bus_read_value_in  in  32  read data, valid when bus_ready_in
- bus_ready_in  in  1  transaction complete this cycle
- valid_out  out  1  writeback bundle valid (one-cycle pulse per instruction)
- rd_out  out  5  destination register
- rd_write_out  out  1  register-file write enable
- rd_value_out  out  32  writeback value
- trap_out  out  1  misaligned-access trap (see Optional Feature)

Behaviour:
- States IDLE and BUS. Reset: state=IDLE; all outputs 0, including strobes, mask, valid_out and trap_out.
- stall_out = (state==BUS) && !bus_ready_in. It is combinational.
- IDLE, valid_in && !flush_in && !read_in && !write_in:
  - Next cycle: valid_out=1, rd_out=rd_in, rd_write_out=rd_write_in, rd_value_out=result_in. Latency 1.
- IDLE, valid_in && !flush_in && (read_in || write_in):
  - Capture address, width, extend, rd, store data.
  - Next cycle: state=BUS and bus strobes asserted; valid_out=0.
- IDLE, flush_in or !valid_in: valid_out=0 next cycle.
- BUS: address, strobes, mask and write value are held stable until the cycle bus_ready_in=1.
  - On that edge: state=IDLE and strobes drop.
  - Next cycle valid_out=1. Minimum ld/st latency is 2 cycles.
  - Stores: rd_write_out=0.
  - Loads: rd_write_out=captured rd_write. A load to x0 still issues the bus read.
- flush_in while in BUS: the transaction runs to completion (not aborted), but the resulting valid_out is suppressed (0). A flush seen at any cycle of BUS latches a kill bit.
- read_in && write_in both set: treated as a store.
- Store lanes, with a = address[1:0]:
  - byte: data replicated 4x; mask = 0001<<a.
  - half: data replicated 2x; mask = 0011 if a[1]==0, else 1100.
  - word: mask 1111.
- Load extract:
  - byte: bus_read_value_in[8a+7:8a].
  - half: bits[15:0] or [31:16] selected by a[1].
  - Sign- or zero-extended per zero_extend_in.
- Without the feature, address bits below the access size are ignored: half uses a[1] only; word ignores a.
- Reset mid-BUS: state=IDLE and strobes=0 on the reset edge. The bus must tolerate a dropped request.
- No new instruction is captured in BUS. Upstream is held by stall_out.

Optional Feature:
- Macro: RV32_MISALIGNED_TRAP_EN.
- Defined: at capture, half with a[0]=1, or word with a!=0, is misaligned.
  - No bus access, state stays IDLE.
  - Next cycle: valid_out=1, trap_out=1, rd_write_out=0, rd_value_out=faulting address.
  - flush_in suppresses the trap.
- Undefined: trap_out tied 0 and the alignment rule above (low bits ignored) applies.

Test Plan:
- ADD passthrough: valid_in, result_in=0x0000_1234, rd_in=5, rd_write_in=1 -> next cycle valid_out=1, rd_out=5, rd_value_out=0x0000_1234, no bus strobe.
- SB address 0x1003, rs2=0xAABBCCDD -> bus_address_out=0x1000, mask=1000, write_value=0xDDDDDDDD; bus_ready_in after 3 cycles -> stall_out high 3 cycles, then valid_out=1, rd_write_out=0.
- LH address 0x2002 signed, bus_read_value_in=0x8001_7FFF -> rd_value_out=0xFFFF_8001; same access with LHU -> 0x0000_8001.
- LW in BUS, flush_in pulsed during wait -> bus read completes, valid_out stays 0, next instruction accepted the cycle after ready.
- Reset asserted mid-BUS -> next cycle state IDLE, bus_read_out=0, valid_out=0, stall_out=0.
- With RV32_MISALIGNED_TRAP_EN, LW at 0x3001 -> no bus strobe, next cycle trap_out=1, valid_out=1, rd_value_out=0x0000_3001. Without the macro -> bus read at 0x3000.

Source files
------------

// File: rtl/rv32_mem.sv
// rv32_mem: RV32I memory-access stage between rv32_alu and writeback.
// Runs one outstanding request/ready bus transaction and registers the writeback bundle.
//
// Ports:
//   clk, reset (synchronous, active-high)
//   upstream : valid_in, flush_in, read_in, write_in, width_in, zero_extend_in,
//              rd_in, rd_write_in, result_in, rs2_value_in, stall_out
//   data bus : bus_address_out, bus_read_out, bus_write_out, bus_write_mask_out,
//              bus_write_value_out, bus_read_value_in, bus_ready_in
//   writeback: valid_out, rd_out, rd_write_out, rd_value_out, trap_out
//
// Optional feature macro: RV32_MISALIGNED_TRAP_EN
//   defined   -> misaligned half/word accesses trap instead of touching the bus
//   undefined -> trap_out is 0 and address bits below the access size are ignored
module rv32_mem (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic        flush_in,
    input  logic        read_in,
    input  logic        write_in,
    input  logic [1:0]  width_in,
    input  logic        zero_extend_in,
    input  logic [4:0]  rd_in,
    input  logic        rd_write_in,
    input  logic [31:0] result_in,
    input  logic [31:0] rs2_value_in,
    output logic        stall_out,
    output logic [31:0] bus_address_out,
    output logic        bus_read_out,
    output logic        bus_write_out,
    output logic [3:0]  bus_write_mask_out,
    output logic [31:0] bus_write_value_out,
    input  logic [31:0] bus_read_value_in,
    input  logic        bus_ready_in,
    output logic        valid_out,
    output logic [4:0]  rd_out,
    output logic        rd_write_out,
    output logic [31:0] rd_value_out,
    output logic        trap_out
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUS  = 1'b1;

    logic [0:0]  r_state;
    logic [31:0] r_addr;
    logic [1:0]  r_width;
    logic        r_zext;
    logic [4:0]  r_rd;
    logic        r_rd_write;
    logic        r_kill;
    logic        r_bus_read;
    logic        r_bus_write;
    logic [3:0]  r_mask;
    logic [31:0] r_wdata;
    logic        r_valid;
    logic [4:0]  r_rd_out;
    logic        r_rd_write_out;
    logic [31:0] r_rd_value;
    logic        r_trap;

    logic        w_accept;
    logic        w_mem;
    logic [1:0]  w_a;
    logic [3:0]  w_st_mask;
    logic [31:0] w_st_data;
    logic [31:0] w_ld_shift;
    logic [15:0] w_ld_half;
    logic [31:0] w_ld_value;
    logic        w_misaligned;
    logic        w_killed;

    assign w_accept = (r_state == S_IDLE) && valid_in && !flush_in;
    assign w_mem    = read_in || write_in;
    assign w_a      = result_in[1:0];
    // A flush on the completing cycle kills the result just like an earlier one.
    assign w_killed = r_kill || flush_in;

    // Store lane placement: data replicated so any lane the mask picks is correct.
    always_comb begin
        w_st_mask = 4'b1111;
        w_st_data = rs2_value_in;
        case (width_in)
            2'b00: begin
                w_st_mask = 4'b0001 << w_a;
                w_st_data = {4{rs2_value_in[7:0]}};
            end
            2'b01: begin
                w_st_mask = w_a[1] ? 4'b1100 : 4'b0011;
                w_st_data = {2{rs2_value_in[15:0]}};
            end
            default: begin
                w_st_mask = 4'b1111;
                w_st_data = rs2_value_in;
            end
        endcase
    end

    // Load extraction from the captured address offset.
    assign w_ld_shift = bus_read_value_in >> {r_addr[1:0], 3'b000};
    assign w_ld_half  = r_addr[1] ? bus_read_value_in[31:16]
                                  : bus_read_value_in[15:0];

    always_comb begin
        w_ld_value = bus_read_value_in;
        case (r_width)
            2'b00:   w_ld_value = {{24{!r_zext && w_ld_shift[7]}},
                                   w_ld_shift[7:0]};
            2'b01:   w_ld_value = {{16{!r_zext && w_ld_half[15]}},
                                   w_ld_half};
            default: w_ld_value = bus_read_value_in;
        endcase
    end

`ifdef RV32_MISALIGNED_TRAP_EN
    always_comb begin
        w_misaligned = 1'b0;
        case (width_in)
            2'b00:   w_misaligned = 1'b0;
            2'b01:   w_misaligned = w_a[0];
            default: w_misaligned = (w_a != 2'b00);
        endcase
    end
`else
    assign w_misaligned = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_addr         <= 32'h0;
            r_width        <= 2'b00;
            r_zext         <= 1'b0;
            r_rd           <= 5'd0;
            r_rd_write     <= 1'b0;
            r_kill         <= 1'b0;
            r_bus_read     <= 1'b0;
            r_bus_write    <= 1'b0;
            r_mask         <= 4'b0000;
            r_wdata        <= 32'h0;
            r_valid        <= 1'b0;
            r_rd_out       <= 5'd0;
            r_rd_write_out <= 1'b0;
            r_rd_value     <= 32'h0;
            r_trap         <= 1'b0;
        end else begin
            // Writeback is a one-cycle pulse; write enable never outlives it.
            r_valid        <= 1'b0;
            r_rd_write_out <= 1'b0;
            r_trap         <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_mem && w_misaligned) begin
                            r_valid    <= 1'b1;
                            r_trap     <= 1'b1;
                            r_rd_out   <= rd_in;
                            r_rd_value <= result_in;
                        end else if (w_mem) begin
                            // read+write together is handled as a store
                            r_state     <= S_BUS;
                            r_addr      <= result_in;
                            r_width     <= width_in;
                            r_zext      <= zero_extend_in;
                            r_rd        <= rd_in;
                            r_rd_write  <= rd_write_in;
                            r_kill      <= 1'b0;
                            r_bus_read  <= !write_in;
                            r_bus_write <= write_in;
                            r_mask      <= write_in ? w_st_mask : 4'b0000;
                            r_wdata     <= write_in ? w_st_data : 32'h0;
                        end else begin
                            r_valid        <= 1'b1;
                            r_rd_out       <= rd_in;
                            r_rd_write_out <= rd_write_in;
                            r_rd_value     <= result_in;
                        end
                    end
                end
                S_BUS: begin
                    if (flush_in) begin
                        r_kill <= 1'b1;
                    end
                    if (bus_ready_in) begin
                        r_state        <= S_IDLE;
                        r_bus_read     <= 1'b0;
                        r_bus_write    <= 1'b0;
                        r_mask         <= 4'b0000;
                        r_valid        <= !w_killed;
                        r_rd_out       <= r_rd;
                        r_rd_write_out <= !w_killed && !r_bus_write
                                          && r_rd_write;
                        r_rd_value     <= r_bus_write ? 32'h0 : w_ld_value;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stall_out           = (r_state == S_BUS) && !bus_ready_in;
    assign bus_address_out     = {r_addr[31:2], 2'b00};
    assign bus_read_out        = r_bus_read;
    assign bus_write_out       = r_bus_write;
    assign bus_write_mask_out  = r_mask;
    assign bus_write_value_out = r_wdata;
    assign valid_out           = r_valid;
    assign rd_out              = r_rd_out;
    assign rd_write_out        = r_rd_write_out;
    assign rd_value_out        = r_rd_value;
    assign trap_out            = r_trap;

endmodule

// File: tb/tb_rv32_mem.sv
// tb_rv32_mem: directed self-checking bench for rv32_mem.
// Inputs driven 1 ns after the rising edge, outputs sampled there too.
module tb_rv32_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in, flush_in, read_in, write_in;
    logic [1:0]  width_in;
    logic        zero_extend_in;
    logic [4:0]  rd_in;
    logic        rd_write_in;
    logic [31:0] result_in, rs2_value_in;
    logic        stall_out;
    logic [31:0] bus_address_out;
    logic        bus_read_out, bus_write_out;
    logic [3:0]  bus_write_mask_out;
    logic [31:0] bus_write_value_out;
    logic [31:0] bus_read_value_in;
    logic        bus_ready_in;
    logic        valid_out;
    logic [4:0]  rd_out;
    logic        rd_write_out;
    logic [31:0] rd_value_out;
    logic        trap_out;

    int n_checks = 0;
    int n_pass   = 0;

    rv32_mem dut (
        .clk                 (clk),
        .reset               (reset),
        .valid_in            (valid_in),
        .flush_in            (flush_in),
        .read_in             (read_in),
        .write_in            (write_in),
        .width_in            (width_in),
        .zero_extend_in      (zero_extend_in),
        .rd_in               (rd_in),
        .rd_write_in         (rd_write_in),
        .result_in           (result_in),
        .rs2_value_in        (rs2_value_in),
        .stall_out           (stall_out),
        .bus_address_out     (bus_address_out),
        .bus_read_out        (bus_read_out),
        .bus_write_out       (bus_write_out),
        .bus_write_mask_out  (bus_write_mask_out),
        .bus_write_value_out (bus_write_value_out),
        .bus_read_value_in   (bus_read_value_in),
        .bus_ready_in        (bus_ready_in),
        .valid_out           (valid_out),
        .rd_out              (rd_out),
        .rd_write_out        (rd_write_out),
        .rd_value_out        (rd_value_out),
        .trap_out            (trap_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        valid_in = 0; flush_in = 0; read_in = 0; write_in = 0;
        width_in = 2'b10; zero_extend_in = 0; rd_in = 0;
        rd_write_in = 0; result_in = 0; rs2_value_in = 0;
        bus_read_value_in = 0; bus_ready_in = 0;
    endtask

    task automatic issue(input logic rd, input logic wr,
                         input logic [1:0] w, input logic zx,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] rdn);
        valid_in = 1; read_in = rd; write_in = wr; width_in = w;
        zero_extend_in = zx; result_in = addr; rs2_value_in = data;
        rd_in = rdn; rd_write_in = 1;
        tick();
        clear_in();
    endtask

    task automatic do_load(input string tag, input logic [1:0] w,
                           input logic zx, input logic [31:0] addr,
                           input logic [31:0] rdata,
                           input logic [31:0] exp);
        issue(1, 0, w, zx, addr, 32'h0, 5'd9);
        chk({tag, "_rd"}, bus_read_out, 1);
        chk({tag, "_addr"}, bus_address_out, {addr[31:2], 2'b00});
        bus_ready_in = 1; bus_read_value_in = rdata;
        tick();
        clear_in();
        chk({tag, "_valid"}, valid_out, 1);
        chk({tag, "_rdw"}, rd_write_out, 1);
        chk({tag, "_val"}, rd_value_out, exp);
    endtask

    task automatic do_store(input string tag, input logic [1:0] w,
                            input logic [31:0] addr,
                            input logic [31:0] data,
                            input logic [3:0] emask,
                            input logic [31:0] ewdata);
        issue(0, 1, w, 0, addr, data, 5'd3);
        chk({tag, "_wr"}, bus_write_out, 1);
        chk({tag, "_mask"}, bus_write_mask_out, emask);
        chk({tag, "_wdata"}, bus_write_value_out, ewdata);
        bus_ready_in = 1;
        tick();
        clear_in();
        chk({tag, "_valid"}, valid_out, 1);
        chk({tag, "_rdw"}, rd_write_out, 0);
    endtask

    initial begin
        clear_in();
        reset = 1;
        tick(); tick();
        reset = 0;
        tick();
        chk("rst_valid", valid_out, 0);
        chk("rst_rd", bus_read_out, 0);
        chk("rst_wr", bus_write_out, 0);
        chk("rst_mask", bus_write_mask_out, 0);
        chk("rst_stall", stall_out, 0);
        chk("rst_trap", trap_out, 0);
        chk("rst_rdw", rd_write_out, 0);

        // ADD passthrough
        valid_in = 1; result_in = 32'h0000_1234; rd_in = 5; rd_write_in = 1;
        tick();
        clear_in();
        chk("add_valid", valid_out, 1);
        chk("add_rd", rd_out, 5);
        chk("add_rdw", rd_write_out, 1);
        chk("add_val", rd_value_out, 32'h0000_1234);
        chk("add_bus", {bus_read_out, bus_write_out}, 0);
        tick();
        chk("add_pulse", valid_out, 0);

        // flushed instruction in IDLE produces nothing
        valid_in = 1; flush_in = 1; result_in = 32'h55; rd_write_in = 1;
        tick();
        clear_in();
        chk("iflush_valid", valid_out, 0);

        // SB 0x1003 with 3 wait cycles
        issue(0, 1, 2'b00, 0, 32'h0000_1003, 32'hAABB_CCDD, 5'd7);
        chk("sb_addr", bus_address_out, 32'h0000_1000);
        chk("sb_mask", bus_write_mask_out, 4'b1000);
        chk("sb_wdata", bus_write_value_out, 32'hDDDD_DDDD);
        chk("sb_wr", bus_write_out, 1);
        chk("sb_rd", bus_read_out, 0);
        for (int i = 0; i < 3; i++) begin
            chk("sb_stall", stall_out, 1);
            chk("sb_hold", bus_address_out, 32'h0000_1000);
            chk("sb_nvalid", valid_out, 0);
            tick();
        end
        bus_ready_in = 1;
        #1;
        chk("sb_stall_rdy", stall_out, 0);
        tick();
        clear_in();
        chk("sb_valid", valid_out, 1);
        chk("sb_rdw", rd_write_out, 0);
        chk("sb_wr_drop", bus_write_out, 0);
        chk("sb_stall_end", stall_out, 0);

        do_store("sh", 2'b01, 32'h0000_1002, 32'h1122_3344,
                 4'b1100, 32'h3344_3344);
        do_store("sw", 2'b10, 32'h0000_1004, 32'h1122_3344,
                 4'b1111, 32'h1122_3344);
        do_store("sw11", 2'b11, 32'h0000_1008, 32'hCAFE_F00D,
                 4'b1111, 32'hCAFE_F00D);

        do_load("lh", 2'b01, 0, 32'h0000_2002, 32'h8001_7FFF, 32'hFFFF_8001);
        do_load("lhu", 2'b01, 1, 32'h0000_2002, 32'h8001_7FFF, 32'h0000_8001);
        do_load("lh_lo", 2'b01, 0, 32'h0000_2000, 32'h8001_7FFF, 32'h0000_7FFF);
        do_load("lb", 2'b00, 0, 32'h0000_2001, 32'h1234_80FF, 32'hFFFF_FF80);
        do_load("lbu", 2'b00, 1, 32'h0000_2003, 32'h1234_80FF, 32'h0000_0012);
        do_load("lw", 2'b10, 0, 32'h0000_2000, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        // LW flushed while waiting
        issue(1, 0, 2'b10, 0, 32'h0000_4000, 32'h0, 5'd4);
        tick();
        flush_in = 1;
        tick();
        flush_in = 0;
        chk("fl_rd_held", bus_read_out, 1);
        chk("fl_stall", stall_out, 1);
        bus_ready_in = 1; bus_read_value_in = 32'h1111_2222;
        tick();
        clear_in();
        chk("fl_valid", valid_out, 0);
        chk("fl_rdw", rd_write_out, 0);
        chk("fl_rd_drop", bus_read_out, 0);
        valid_in = 1; result_in = 32'h0000_0077; rd_in = 6; rd_write_in = 1;
        tick();
        clear_in();
        chk("fl_next_valid", valid_out, 1);
        chk("fl_next_val", rd_value_out, 32'h0000_0077);

        // reset mid-BUS
        issue(1, 0, 2'b10, 0, 32'h0000_5000, 32'h0, 5'd8);
        chk("rb_rd", bus_read_out, 1);
        reset = 1;
        tick();
        reset = 0;
        chk("rb_rd_drop", bus_read_out, 0);
        chk("rb_valid", valid_out, 0);
        chk("rb_stall", stall_out, 0);

        // misaligned word load
        issue(1, 0, 2'b10, 0, 32'h0000_3001, 32'h0, 5'd2);
`ifdef RV32_MISALIGNED_TRAP_EN
        chk("mis_rd", bus_read_out, 0);
        chk("mis_trap", trap_out, 1);
        chk("mis_valid", valid_out, 1);
        chk("mis_rdw", rd_write_out, 0);
        chk("mis_val", rd_value_out, 32'h0000_3001);
        tick();
        chk("mis_trap_pulse", trap_out, 0);
`else
        chk("mis_rd", bus_read_out, 1);
        chk("mis_addr", bus_address_out, 32'h0000_3000);
        bus_ready_in = 1; bus_read_value_in = 32'h0BAD_F00D;
        tick();
        clear_in();
        chk("mis_trap", trap_out, 0);
        chk("mis_valid", valid_out, 1);
        chk("mis_val", rd_value_out, 32'h0BAD_F00D);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
